// File: rtl/xeng_pkg.sv
// Shared constants and helpers for the X-engine pair readout: ceil-log2, triangular pair count
// and the accumulator word width.
package xeng_pkg;

  function automatic int log2c(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int npairs(input int n);
    return n * (n + 1) / 2;
  endfunction

  function automatic int acc_width(input int input_width, input int acc_len_bits);
    return input_width + acc_len_bits;
  endfunction

endpackage

// File: rtl/xeng_pair_index_gen.sv
// Triangular antenna-pair counter: on start walks (a,b) with a<=b from (0,0) to (N-1,N-1),
// one pair per cycle; abort stops it. Indices hold their last value while idle.
module xeng_pair_index_gen
  import xeng_pkg::*;
#(
  parameter int N   = 4,
  parameter int VLB = log2c(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic           abort_i,
  output logic [VLB-1:0] a_o,
  output logic [VLB-1:0] b_o,
  output logic           valid_o,
  output logic           first_o,
  output logic           last_o
);

  localparam logic [VLB-1:0] LAST_IDX = VLB'(N - 1);
  localparam logic [VLB-1:0] ONE      = VLB'(1);

  logic [VLB-1:0] a_q, a_d;
  logic [VLB-1:0] b_q, b_d;
  logic           valid_q, valid_d;

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign valid_o = valid_q;
  assign first_o = valid_q && (a_q == '0) && (b_q == '0);
  assign last_o  = valid_q && (a_q == LAST_IDX) && (b_q == LAST_IDX);

  // A start on the final pair simply restarts, so back-to-back scans need no gap.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    if (abort_i) begin
      valid_d = 1'b0;
    end else if (start_i) begin
      a_d     = '0;
      b_d     = '0;
      valid_d = 1'b1;
    end else if (valid_q) begin
      if (last_o) begin
        valid_d = 1'b0;
      end else if (b_q == LAST_IDX) begin
        a_d = a_q + ONE;
        b_d = a_q + ONE;
      end else begin
        b_d = b_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/xeng_pair_readout.sv
// Mirrors the vector accumulator's double-buffer schedule, scans every antenna pair of each
// completed buffer and emits the registered signed product of the two returned accumulations.
module xeng_pair_readout
  import xeng_pkg::*;
#(
  parameter  int INPUT_WIDTH   = 4,
  parameter  int ACC_LEN_BITS  = 8,
  parameter  int VECTOR_LENGTH = 32,
  parameter  int VACC_LATENCY  = 2,
  localparam int ACC_WIDTH     = acc_width(INPUT_WIDTH, ACC_LEN_BITS),
  localparam int VLB           = log2c(VECTOR_LENGTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sync,
  input  logic signed [ACC_WIDTH-1:0]   din_a,
  input  logic signed [ACC_WIDTH-1:0]   din_b,
  output logic        [VLB-1:0]         ant_sel_a,
  output logic        [VLB-1:0]         ant_sel_b,
  output logic                          buf_sel,
  output logic signed [2*ACC_WIDTH-1:0] dout,
  output logic                          dout_valid,
  output logic        [VLB-1:0]         dout_ant_a,
  output logic        [VLB-1:0]         dout_ant_b,
  output logic                          dout_sof,
  output logic                          dout_eof,
  output logic                          overrun
);

  localparam int FRAME = VECTOR_LENGTH << ACC_LEN_BITS;
  localparam int CNT_W = log2c(FRAME);
  localparam int TAG_W = 3 + 2 * VLB;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             frame_done;
  logic             buf_sel_q;
  logic             overrun_q;

  logic [VLB-1:0] scan_a, scan_b;
  logic           scan_valid, scan_first, scan_last;

  always_comb begin
    cnt_d      = cnt_q + CNT_ONE;
    active_d   = active_q;
    frame_done = 1'b0;
    if (sync) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d      = '0;
      active_d   = ~active_q;
      frame_done = 1'b1;
    end
  end

  // The buffer just finished is the one being left, i.e. the pre-toggle active_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      active_q  <= 1'b0;
      buf_sel_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      overrun_q <= frame_done && scan_valid && !scan_last;
      if (frame_done) buf_sel_q <= active_q;
    end
  end

  xeng_pair_index_gen #(
    .N   (VECTOR_LENGTH),
    .VLB (VLB)
  ) u_index_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (frame_done),
    .abort_i (sync),
    .a_o     (scan_a),
    .b_o     (scan_b),
    .valid_o (scan_valid),
    .first_o (scan_first),
    .last_o  (scan_last)
  );

  assign ant_sel_a = scan_a;
  assign ant_sel_b = scan_b;
  assign buf_sel   = buf_sel_q;
  assign overrun   = overrun_q;

  // Tag layout: {valid, sof, eof, a, b}; only the valid bit is killed by sync.
  logic [TAG_W-1:0] tag_pipe [VACC_LATENCY+1];
  assign tag_pipe[0] = {scan_valid, scan_first, scan_last, scan_a, scan_b};

  for (genvar gi = 0; gi < VACC_LATENCY; gi++) begin : g_tag
    logic [TAG_W-1:0] stage_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stage_q <= '0;
      else        stage_q <= sync ? {1'b0, tag_pipe[gi][TAG_W-2:0]} : tag_pipe[gi];
    end
    assign tag_pipe[gi+1] = stage_q;
  end

  logic [TAG_W-1:0] tag_out;
  logic             tag_v;
  assign tag_out = tag_pipe[VACC_LATENCY];
  assign tag_v   = tag_out[TAG_W-1];

  logic signed [2*ACC_WIDTH-1:0] prod;
  assign prod = $signed({{ACC_WIDTH{din_a[ACC_WIDTH-1]}}, din_a})
              * $signed({{ACC_WIDTH{din_b[ACC_WIDTH-1]}}, din_b});

  logic signed [2*ACC_WIDTH-1:0] dout_q;
  logic                          dout_valid_q, sof_q, eof_q;
  logic        [VLB-1:0]         ant_a_q, ant_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      ant_a_q      <= '0;
      ant_b_q      <= '0;
    end else begin
      dout_valid_q <= tag_v && !sync;
      sof_q        <= tag_v && tag_out[TAG_W-2] && !sync;
      eof_q        <= tag_v && tag_out[TAG_W-3] && !sync;
      if (tag_v) begin
        dout_q  <= prod;
        ant_a_q <= tag_out[2*VLB-1:VLB];
        ant_b_q <= tag_out[VLB-1:0];
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_sof   = sof_q;
  assign dout_eof   = eof_q;
  assign dout_ant_a = ant_a_q;
  assign dout_ant_b = ant_b_q;

endmodule

// File: tb/tb_xeng_pair_readout.sv
// Directed bench: behavioural two-buffer accumulator with 2-cycle read latency feeding two
// readout instances (N=4/FRAME=16 and N=8/FRAME=16), checked against hand-computed pair products.
module tb_xeng_pair_readout;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sync4 = 1'b0;
  logic sync8 = 1'b0;
  always #5 clk = ~clk;

  // N=4, ACC_LEN_BITS=2: ACC_WIDTH=6, VLB=2
  logic signed [5:0]  da4, db4, ra4, rb4;
  logic        [1:0]  sa4, sb4, aa4, ab4;
  logic               bs4, v4, sof4, eof4, ov4;
  logic signed [11:0] d4;
  logic signed [5:0]  mem4 [2][4];

  // N=8, ACC_LEN_BITS=1: ACC_WIDTH=5, VLB=3
  logic signed [4:0]  da8, db8, ra8, rb8;
  logic        [2:0]  sa8, sb8, aa8, ab8;
  logic               bs8, v8, sof8, eof8, ov8;
  logic signed [9:0]  d8;
  logic signed [4:0]  mem8 [2][8];

  xeng_pair_readout #(.INPUT_WIDTH(4), .ACC_LEN_BITS(2), .VECTOR_LENGTH(4), .VACC_LATENCY(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .sync(sync4), .din_a(da4), .din_b(db4),
    .ant_sel_a(sa4), .ant_sel_b(sb4), .buf_sel(bs4), .dout(d4), .dout_valid(v4),
    .dout_ant_a(aa4), .dout_ant_b(ab4), .dout_sof(sof4), .dout_eof(eof4), .overrun(ov4));

  xeng_pair_readout #(.INPUT_WIDTH(4), .ACC_LEN_BITS(1), .VECTOR_LENGTH(8), .VACC_LATENCY(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .sync(sync8), .din_a(da8), .din_b(db8),
    .ant_sel_a(sa8), .ant_sel_b(sb8), .buf_sel(bs8), .dout(d8), .dout_valid(v8),
    .dout_ant_a(aa8), .dout_ant_b(ab8), .dout_sof(sof8), .dout_eof(eof8), .overrun(ov8));

  // Accumulator read model: address registered, then output register.
  always @(posedge clk) begin
    ra4 <= mem4[bs4][sa4]; rb4 <= mem4[bs4][sb4]; da4 <= ra4; db4 <= rb4;
    ra8 <= mem8[bs8][sa8]; rb8 <= mem8[bs8][sb8]; da8 <= ra8; db8 <= rb8;
  end

  typedef struct {
    bit v, sof, eof, bs, ov;
    int a, b, sa, sb, d;
  } rec_t;
  rec_t log4[$];
  rec_t log8[$];

  always @(negedge clk) begin
    rec_t r4, r8;
    r4.v = v4; r4.sof = sof4; r4.eof = eof4; r4.bs = bs4; r4.ov = ov4;
    r4.a = int'(aa4); r4.b = int'(ab4); r4.sa = int'(sa4); r4.sb = int'(sb4); r4.d = int'(d4);
    r8.v = v8; r8.sof = sof8; r8.eof = eof8; r8.bs = bs8; r8.ov = ov8;
    r8.a = int'(aa8); r8.b = int'(ab8); r8.sa = int'(sa8); r8.sb = int'(sb8); r8.d = int'(d8);
    log4.push_back(r4);
    log8.push_back(r8);
  end

  int checks = 0;
  int errors = 0;
  int pa4[10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
  int pb4[10] = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3};

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Sync is seen by exactly one rising edge; record 0 is then the state after the next edge.
  task automatic do_sync4();
    @(negedge clk); #1 sync4 = 1'b1;
    @(negedge clk); #1 sync4 = 1'b0;
    log4.delete();
  endtask

  task automatic do_sync8();
    @(negedge clk); #1 sync8 = 1'b1;
    @(negedge clk); #1 sync8 = 1'b0;
    log8.delete();
  endtask

  task automatic test_reset();
    #23;
    checks++;
    if ({sa4, sb4, bs4, d4, v4, aa4, ab4, sof4, eof4, ov4} !== '0) begin
      errors++;
      $display("FAIL reset_outputs4 got %h expected 0", {sa4, sb4, bs4, d4, v4, aa4, ab4, sof4, eof4, ov4});
    end
    checks++;
    if ({sa8, sb8, bs8, d8, v8, aa8, ab8, sof8, eof8, ov8} !== '0) begin
      errors++;
      $display("FAIL reset_outputs8 got %h expected 0", {sa8, sb8, bs8, d8, v8, aa8, ab8, sof8, eof8, ov8});
    end
    @(negedge clk); #1 rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_order();
    int n;
    do_sync4();
    run(31);
    n = 0;
    for (int r = 0; r < 18; r++) if (log4[r].v) n++;
    checks++;
    if (n != 0) begin errors++; $display("FAIL order_early_valid got %0d expected 0", n); end
    for (int k = 0; k < 10; k++) begin
      rec_t s, o;
      int exp_d;
      s = log4[15 + k];
      o = log4[18 + k];
      exp_d = int'(mem4[0][pa4[k]]) * int'(mem4[0][pb4[k]]);
      checks++;
      if (s.sa != pa4[k] || s.sb != pb4[k] || s.bs != 1'b0) begin
        errors++;
        $display("FAIL order_antsel[%0d] got (%0d,%0d) buf %0d expected (%0d,%0d) buf 0", k, s.sa, s.sb, s.bs, pa4[k], pb4[k]);
      end
      checks++;
      if (!o.v || o.a != pa4[k] || o.b != pb4[k] || o.sof != (k == 0) || o.eof != (k == 9)) begin
        errors++;
        $display("FAIL order_tag[%0d] got v%0d (%0d,%0d) sof%0d eof%0d expected v1 (%0d,%0d) sof%0d eof%0d",
                 k, o.v, o.a, o.b, o.sof, o.eof, pa4[k], pb4[k], k == 0, k == 9);
      end
      checks++;
      if (o.d != exp_d) begin errors++; $display("FAIL order_dout[%0d] got %0d expected %0d", k, o.d, exp_d); end
    end
    checks++;
    if (log4[28].v) begin errors++; $display("FAIL order_tail_valid got 1 expected 0"); end
    $display("test_order done");
  endtask

  task automatic test_arith();
    checks++;
    if (log4[19].d != -35 || 12'(log4[19].d) !== 12'hFDD) begin
      errors++; $display("FAIL arith_neg got %0d expected -35 (0xFDD)", log4[19].d);
    end
    checks++;
    if (log4[25].d != 1024) begin errors++; $display("FAIL arith_min got %0d expected 1024", log4[25].d); end
    $display("test_arith done");
  endtask

  task automatic test_buffers();
    int old0[4], new0[4], one[4];
    int n;
    for (int i = 0; i < 4; i++) begin old0[i] = int'(mem4[0][i]); one[i] = int'(mem4[1][i]); end
    run(5);
    mem4[0][0] = 6'sd11; mem4[0][1] = -6'sd9; mem4[0][2] = 6'sd1; mem4[0][3] = -6'sd20;
    for (int i = 0; i < 4; i++) new0[i] = int'(mem4[0][i]);
    run(30);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (log4[31 + k].bs != 1'b1 || log4[47 + k].bs != 1'b0) begin
        errors++; $display("FAIL buf_sel[%0d] got %0d,%0d expected 1,0", k, log4[31 + k].bs, log4[47 + k].bs);
      end
      checks++;
      if (!log4[34 + k].v || log4[34 + k].d != one[pa4[k]] * one[pb4[k]]) begin
        errors++; $display("FAIL buf1_dout[%0d] got v%0d %0d expected v1 %0d", k, log4[34 + k].v, log4[34 + k].d, one[pa4[k]] * one[pb4[k]]);
      end
      checks++;
      if (!log4[50 + k].v || log4[50 + k].d != new0[pa4[k]] * new0[pb4[k]]) begin
        errors++; $display("FAIL buf0_dout[%0d] got v%0d %0d expected v1 %0d", k, log4[50 + k].v, log4[50 + k].d, new0[pa4[k]] * new0[pb4[k]]);
      end
    end
    checks++;
    if (log4[18].d != old0[0] * old0[0]) begin errors++; $display("FAIL buf0_first got %0d expected %0d", log4[18].d, old0[0] * old0[0]); end
    n = 0;
    for (int r = 0; r < 66; r++) if (log4[r].ov) n++;
    checks++;
    if (n != 0) begin errors++; $display("FAIL buf_overrun got %0d expected 0", n); end
    $display("test_buffers done");
  endtask

  task automatic test_sync_abort();
    int nv_pre, nv_post, ne, no;
    do_sync4();
    run(21);
    checks++;
    if (log4[20].sa != 1 || log4[20].sb != 2) begin
      errors++; $display("FAIL abort_pair5 got (%0d,%0d) expected (1,2)", log4[20].sa, log4[20].sb);
    end
    sync4 = 1'b1;
    @(negedge clk); #1 sync4 = 1'b0;
    run(24);
    nv_pre = 0; nv_post = 0; ne = 0; no = 0;
    for (int r = 18; r < 21; r++) if (log4[r].v) nv_pre++;
    for (int r = 21; r < 40; r++) if (log4[r].v) nv_post++;
    for (int r = 0; r < 40; r++) begin if (log4[r].eof) ne++; if (log4[r].ov) no++; end
    checks++;
    if (nv_pre != 3) begin errors++; $display("FAIL abort_pre_valid got %0d expected 3", nv_pre); end
    checks++;
    if (nv_post != 0) begin errors++; $display("FAIL abort_post_valid got %0d expected 0", nv_post); end
    checks++;
    if (ne != 0 || no != 0) begin errors++; $display("FAIL abort_eof_ovr got eof %0d ovr %0d expected 0 0", ne, no); end
    checks++;
    if (!log4[40].v || !log4[40].sof || log4[40].a != 0 || log4[40].b != 0 || log4[37].bs != 1'b0 ||
        log4[40].d != int'(mem4[0][0]) * int'(mem4[0][0])) begin
      errors++; $display("FAIL abort_next_scan got v%0d sof%0d (%0d,%0d) d %0d expected v1 sof1 (0,0) d %0d",
                         log4[40].v, log4[40].sof, log4[40].a, log4[40].b, log4[40].d, int'(mem4[0][0]) * int'(mem4[0][0]));
    end
    checks++;
    if (log4[41].a != 0 || log4[41].b != 1) begin errors++; $display("FAIL abort_next_pair got (%0d,%0d) expected (0,1)", log4[41].a, log4[41].b); end
    $display("test_sync_abort done");
  endtask

  task automatic test_overrun();
    int no, ne, nv;
    do_sync8();
    run(37);
    no = 0; ne = 0; nv = 0;
    for (int r = 0; r < 37; r++) begin if (log8[r].ov) no++; if (log8[r].eof) ne++; end
    for (int r = 18; r < 37; r++) if (log8[r].v) nv++;
    checks++;
    if (no != 1 || !log8[31].ov) begin errors++; $display("FAIL ovr_pulse got count %0d at31 %0d expected 1 1", no, log8[31].ov); end
    checks++;
    if (ne != 0) begin errors++; $display("FAIL ovr_no_eof got %0d expected 0", ne); end
    checks++;
    if (nv != 19) begin errors++; $display("FAIL ovr_drain_valid got %0d expected 19", nv); end
    checks++;
    if (log8[30].sa != 2 || log8[30].sb != 2 || log8[30].bs != 1'b0) begin
      errors++; $display("FAIL ovr_before got (%0d,%0d) buf %0d expected (2,2) buf 0", log8[30].sa, log8[30].sb, log8[30].bs);
    end
    checks++;
    if (log8[31].sa != 0 || log8[31].sb != 0 || log8[31].bs != 1'b1 || log8[32].sb != 1) begin
      errors++; $display("FAIL ovr_restart got (%0d,%0d) buf %0d next b %0d expected (0,0) buf 1 next b 1",
                         log8[31].sa, log8[31].sb, log8[31].bs, log8[32].sb);
    end
    checks++;
    if (log8[18].d != 9 || !log8[18].sof) begin errors++; $display("FAIL ovr_first got %0d sof %0d expected 9 sof 1", log8[18].d, log8[18].sof); end
    checks++;
    if (log8[32].a != 1 || log8[32].b != 7 || log8[32].d != 8) begin
      errors++; $display("FAIL ovr_pair14 got (%0d,%0d) %0d expected (1,7) 8", log8[32].a, log8[32].b, log8[32].d);
    end
    checks++;
    if (log8[33].a != 2 || log8[33].b != 2 || log8[33].d != 36 || log8[33].sof) begin
      errors++; $display("FAIL ovr_pair15 got (%0d,%0d) %0d sof %0d expected (2,2) 36 sof 0", log8[33].a, log8[33].b, log8[33].d, log8[33].sof);
    end
    checks++;
    if (!log8[34].sof || log8[34].a != 0 || log8[34].b != 0 || log8[34].d != 81) begin
      errors++; $display("FAIL ovr_new_scan got sof %0d (%0d,%0d) %0d expected sof 1 (0,0) 81", log8[34].sof, log8[34].a, log8[34].b, log8[34].d);
    end
    $display("test_overrun done");
  endtask

  task automatic test_async_reset();
    int n;
    do_sync4();
    run(40);
    @(posedge clk); #3;
    checks++;
    if (v4 !== 1'b1 || bs4 !== 1'b1) begin errors++; $display("FAIL areset_pre got v %0d buf %0d expected 1 1", v4, bs4); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sa4, sb4, bs4, d4, v4, aa4, ab4, sof4, eof4, ov4} !== '0) begin
      errors++; $display("FAIL areset_outputs got %h expected 0", {sa4, sb4, bs4, d4, v4, aa4, ab4, sof4, eof4, ov4});
    end
    @(negedge clk); #1 rst_n = 1'b1;
    log4.delete();
    run(22);
    n = 0;
    for (int r = 0; r < 18; r++) if (log4[r].v) n++;
    checks++;
    if (n != 0) begin errors++; $display("FAIL areset_early_valid got %0d expected 0", n); end
    checks++;
    if (log4[16].sa != 0 || log4[16].sb != 1 || log4[16].bs != 1'b0) begin
      errors++; $display("FAIL areset_scan got (%0d,%0d) buf %0d expected (0,1) buf 0", log4[16].sa, log4[16].sb, log4[16].bs);
    end
    checks++;
    if (!log4[18].v || !log4[18].sof || log4[18].d != int'(mem4[0][0]) * int'(mem4[0][0])) begin
      errors++; $display("FAIL areset_first got v%0d sof%0d %0d expected v1 sof1 %0d", log4[18].v, log4[18].sof, log4[18].d, int'(mem4[0][0]) * int'(mem4[0][0]));
    end
    $display("test_async_reset done");
  endtask

  initial begin
    mem4[0][0] = -6'sd5; mem4[0][1] = 6'sd7;  mem4[0][2] = -6'sd32; mem4[0][3] = 6'sd3;
    mem4[1][0] = 6'sd2;  mem4[1][1] = -6'sd1; mem4[1][2] = 6'sd4;   mem4[1][3] = -6'sd6;
    mem8[0][0] = 5'sd3;  mem8[0][1] = -5'sd4; mem8[0][2] = 5'sd6;   mem8[0][3] = 5'sd1;
    mem8[0][4] = -5'sd7; mem8[0][5] = 5'sd2;  mem8[0][6] = 5'sd5;   mem8[0][7] = -5'sd2;
    mem8[1][0] = -5'sd9; mem8[1][1] = 5'sd4;  mem8[1][2] = -5'sd3;  mem8[1][3] = 5'sd7;
    mem8[1][4] = 5'sd0;  mem8[1][5] = -5'sd16; mem8[1][6] = 5'sd15; mem8[1][7] = 5'sd1;
    test_reset();
    test_order();
    test_arith();
    test_buffers();
    test_sync_abort();
    test_overrun();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
